clkgate_sequencer: RTL and testbench

//  Sequences the enables of NUM_DOMAINS gated global clock buffers, one per

---
 rtl/clkgate_sequencer.sv | 90 +++++++++
 tb/tb_clkgate_sequencer.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/clkgate_sequencer.sv
// clkgate_sequencer: one-at-a-time sequencer for gated clock-buffer CE inputs with settle and ack.
// Define CLKGATE_SEQ_STAGGER_EN to add a STAGGER_CYCLES idle gap after every ack.
module clkgate_sequencer #(
    parameter int NUM_DOMAINS    = 4,
    parameter int SETTLE_CYCLES  = 4,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                   i_clk,
    input  logic                   i_nrst,
    input  logic [NUM_DOMAINS-1:0] i_req,
    input  logic                   i_force_on,
    output logic [NUM_DOMAINS-1:0] o_ce,
    output logic [NUM_DOMAINS-1:0] o_ack,
    output logic                   o_busy
);
    localparam int MAXC = (SETTLE_CYCLES > STAGGER_CYCLES) ? SETTLE_CYCLES : STAGGER_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);
    localparam int PW   = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        SETTLE
`ifdef CLKGATE_SEQ_STAGGER_EN
        , STAGGER
`endif
    } state_t;
    state_t                 state, state_n;
    logic [CW-1:0]          cnt;
    logic [PW-1:0]          sel, ptr, pick;
    logic                   found, settle_done;
    logic [NUM_DOMAINS-1:0] eff, pend;
    assign eff         = i_req | {NUM_DOMAINS{i_force_on}};
    assign pend        = eff ^ o_ack;
    assign settle_done = cnt == CW'(SETTLE_CYCLES - 1);
    assign o_busy      = state != IDLE;
    // descending offsets so the nearest pending domain after ptr wins
    always_comb begin
        pick  = '0;
        found = 1'b0;
        for (int i = NUM_DOMAINS - 1; i >= 0; i--) begin
            if (pend[(int'(ptr) + i) % NUM_DOMAINS]) begin
                pick  = PW'((int'(ptr) + i) % NUM_DOMAINS);
                found = 1'b1;
            end
        end
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = found ? APPLY : IDLE;
            APPLY:   state_n = SETTLE;
`ifdef CLKGATE_SEQ_STAGGER_EN
            SETTLE:  state_n = settle_done ? STAGGER : SETTLE;
            STAGGER: state_n = (cnt == CW'(STAGGER_CYCLES - 1)) ? IDLE : STAGGER;
`else
            SETTLE:  state_n = settle_done ? IDLE : SETTLE;
`endif
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
            ptr   <= '0;
            o_ce  <= '0;
            o_ack <= '0;
        end else begin
            state <= state_n;
            case (state)
                IDLE: if (found) sel <= pick;
                APPLY: begin
                    o_ce[sel] <= eff[sel];
                    cnt       <= '0;
                end
                SETTLE: begin
                    if (settle_done) begin
                        o_ack[sel] <= o_ce[sel];
                        ptr        <= (sel == PW'(NUM_DOMAINS - 1)) ? '0 : sel + 1'b1;
                        cnt        <= '0;
                    end else begin
                        cnt <= (cnt == CW'(MAXC)) ? cnt : cnt + 1'b1;
                    end
                end
                default: cnt <= (cnt == CW'(MAXC)) ? cnt : cnt + 1'b1;
            endcase
        end
    end
endmodule

// File: tb/tb_clkgate_sequencer.sv
// tb_clkgate_sequencer: directed scenarios plus random requests, checked each cycle against a timestamp-based transaction model.
module tb_clkgate_sequencer;
    localparam int N = 4;
    localparam int S = 4;
`ifdef CLKGATE_SEQ_STAGGER_EN
    localparam int G = 8;
`else
    localparam int G = 0;
`endif
    logic         i_clk = 1'b0;
    logic         i_nrst = 1'b0;
    logic [N-1:0] i_req = '0;
    logic         i_force_on = 1'b0;
    logic [N-1:0] o_ce, o_ack;
    logic         o_busy;
    int n_checks = 0;
    int n_fail   = 0;
    logic [N-1:0] m_ce, m_ack;
    int  m_ptr, m_sel, t0, cyc;
    bit  m_busy;
    clkgate_sequencer #(.NUM_DOMAINS(N), .SETTLE_CYCLES(S), .STAGGER_CYCLES(8)) dut (
        .i_clk(i_clk), .i_nrst(i_nrst), .i_req(i_req), .i_force_on(i_force_on),
        .o_ce(o_ce), .o_ack(o_ack), .o_busy(o_busy)
    );
    always #5 i_clk = ~i_clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask
    task automatic model_reset();
        m_ce = '0; m_ack = '0; m_ptr = 0; m_busy = 0; m_sel = 0;
    endtask
    // A transition selected at edge t0 writes CE at t0+1, acks at t0+1+S, frees the block at t0+1+S+G.
    task automatic model_step();
        logic [N-1:0] eff;
        int d;
        eff = i_req | {N{i_force_on}};
        cyc++;
        if (!m_busy) begin
            if ((eff ^ m_ack) != '0) begin
                for (int i = 0; i < N; i++) begin
                    if (eff[(m_ptr + i) % N] != m_ack[(m_ptr + i) % N]) begin
                        m_sel = (m_ptr + i) % N;
                        break;
                    end
                end
                t0 = cyc;
                m_busy = 1;
            end
        end else begin
            d = cyc - t0;
            if (d == 1) m_ce[m_sel] = eff[m_sel];
            if (d == 1 + S) begin
                m_ack[m_sel] = m_ce[m_sel];
                m_ptr = (m_sel + 1) % N;
            end
            if (d == 1 + S + G) m_busy = 0;
        end
    endtask
    task automatic step(input int n);
        repeat (n) begin
            @(posedge i_clk);
            model_step();
            #1;
            check("ce", 32'(o_ce), 32'(m_ce));
            check("ack", 32'(o_ack), 32'(m_ack));
            check("busy", 32'(o_busy), 32'(m_busy));
        end
    endtask
    task automatic wait_ce(input int idx, input logic val);
        int k;
        k = 0;
        while (o_ce[idx] !== val && k < 200) begin
            step(1);
            k++;
        end
        check("wait_ce_timeout", 32'(o_ce[idx]), 32'(val));
    endtask
    initial begin
        cyc = 0;
        model_reset();
        #12;
        check("rst_ce", 32'(o_ce), 0);
        check("rst_ack", 32'(o_ack), 0);
        check("rst_busy", 32'(o_busy), 0);
        i_nrst = 1'b1;
        i_req = 4'b0001;
        step(20);
        i_req = 4'b1111;
        step(4 * (2 + S + G) + 6);
        check("all_on_ack", 32'(o_ack), 32'hF);
        i_req = 4'b1011;
        step(2 + S + G + 4);
        i_req = 4'b1111;
        wait_ce(2, 1'b1);
        i_req[2] = 1'b0;
        step(1);
        i_req[2] = 1'b1;
        step(2 + S + G + 4);
        check("glitch_ce", 32'(o_ce), 32'hF);
        check("glitch_ack", 32'(o_ack), 32'hF);
        i_req = 4'b0000;
        step(4 * (2 + S + G) + 6);
        i_force_on = 1'b1;
        step(4 * (2 + S + G) + 6);
        check("force_on_ack", 32'(o_ack), 32'hF);
        i_force_on = 1'b0;
        step(4 * (2 + S + G) + 6);
        check("force_off_ack", 32'(o_ack), 32'h0);
        i_req = 4'b0010;
        wait_ce(1, 1'b1);
        step(1);
        #2 i_nrst = 1'b0;
        #1;
        check("midrst_ce", 32'(o_ce), 0);
        check("midrst_ack", 32'(o_ack), 0);
        check("midrst_busy", 32'(o_busy), 0);
        model_reset();
        #2 i_nrst = 1'b1;
        step(2 + S + G + 4);
        check("restart_ack", 32'(o_ack), 32'h2);
        #2 i_nrst = 1'b0;
        #1 model_reset();
        #2 i_nrst = 1'b1;
        i_req = 4'b0001;
        step(2 + S + G + 4);
        i_req = 4'b1000;
        wait_ce(3, 1'b1);
        check("rr_order", 32'(o_ce), 32'h9);
        step(2 * (2 + S + G) + 4);
        check("rr_final", 32'(o_ack), 32'h8);
        repeat (3000) begin
            if ($urandom_range(0, 15) == 0) i_req[$urandom_range(0, N - 1)] ^= 1'b1;
            if ($urandom_range(0, 63) == 0) i_force_on = 1'b1;
            else if ($urandom_range(0, 7) == 0) i_force_on = 1'b0;
            step(1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
